// File: rtl/line_buffer_3row.sv
// ---------------------------------------------------------------------------
// line_buffer_3row
//
// Three-row circular line buffer feeding a 3x3 window consumer. Raster-order
// pixels are written into three row memories; once three complete rows are
// held, the consumer pulls one column triple per shift_buffer request.
// Finishing the last column of a window releases the oldest row so the next
// image row can be written into its slot. After the last window of a frame
// a single FLUSH cycle clears all pointers and counters.
//
// Handshakes:
//   write side : a pixel transfers on any rising edge where pix_valid and
//                pix_ready are both high. pix_ready depends only on
//                registered state, never on pix_valid.
//   read side  : a shift transfers on any rising edge where shift_buffer and
//                rows_ready are both high; the column triple appears on
//                l1/l2/l3_out after that edge, flagged by a one-cycle
//                col_valid pulse. shift_buffer with rows_ready low is ignored.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   pix_in        raster-order input pixel
//   pix_valid     pix_in valid
//   pix_ready     block accepts pix_in this cycle
//   shift_buffer  consumer request for the next column triple
//   l1/l2/l3_out  column of the oldest / middle / newest buffered row
//   col_valid     one-cycle pulse marking new l1/l2/l3 values
//   rows_ready    three complete rows are buffered and streamable
//   frame_done    one-cycle pulse while the end-of-frame flush happens
//   fsm_state     current FSM state (FILL=0, STREAM=1, FLUSH=2) for debug
// ---------------------------------------------------------------------------
module line_buffer_3row #(
  parameter int BIT_DEPTH  = 8,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_DEPTH-1:0] pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic                 shift_buffer,
  output logic [BIT_DEPTH-1:0] l1_out,
  output logic [BIT_DEPTH-1:0] l2_out,
  output logic [BIT_DEPTH-1:0] l3_out,
  output logic                 col_valid,
  output logic                 rows_ready,
  output logic                 frame_done,
  output logic [1:0]           fsm_state
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT + 1);

  localparam logic [CW-1:0] COL_LAST    = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] HEIGHT      = RW'(IMG_HEIGHT);
  localparam logic [RW-1:0] LAST_WINDOW = RW'(IMG_HEIGHT - 2);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [BIT_DEPTH-1:0] mem [0:2][0:IMG_WIDTH-1];

  logic [1:0]    wr_row, old_row, mid_row, new_row;
  logic [CW-1:0] wr_col, rd_col;
  logic [RW-1:0] rows_written, windows_done;
  logic [1:0]    filled, filled_next;

  logic wr_accept, row_done, rd_accept, row_release;

  function automatic logic [1:0] row_inc(input logic [1:0] r);
    return (r == 2'd2) ? 2'd0 : r + 2'd1;
  endfunction

  // Handshake and status flags, all from registered state.
  always_comb begin
    pix_ready   = (filled != 2'd3) && (rows_written < HEIGHT) && (state != FLUSH);
    rows_ready  = (filled == 2'd3) && (state == STREAM);
    frame_done  = (state == FLUSH);
    fsm_state   = state;
    wr_accept   = pix_valid && pix_ready;
    row_done    = wr_accept && (wr_col == COL_LAST);
    rd_accept   = shift_buffer && rows_ready;
    row_release = rd_accept && (rd_col == COL_LAST);
    mid_row     = row_inc(old_row);
    new_row     = row_inc(mid_row);
  end

  // A row completing and a row being released in the same cycle cancel out.
  always_comb begin
    filled_next = filled;
    case ({row_done, row_release})
      2'b10:   filled_next = filled + 2'd1;
      2'b01:   filled_next = filled - 2'd1;
      default: filled_next = filled;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (filled_next == 2'd3) state_next = STREAM;
      end
      STREAM: begin
        if (row_release) begin
          if (windows_done + RW'(1) == LAST_WINDOW)
            state_next = FLUSH;
          else if ((filled_next != 2'd3) && (rows_written < HEIGHT))
            state_next = FILL;
        end
      end
      FLUSH:   state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Row memories carry no reset: a location is only read after it was
  // written in the current frame.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_row][wr_col] <= pix_in;
  end

  // Pointers and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row       <= 2'd0;
      old_row      <= 2'd0;
      wr_col       <= '0;
      rd_col       <= '0;
      rows_written <= '0;
      windows_done <= '0;
      filled       <= 2'd0;
    end else if (state == FLUSH) begin
      // The two rows still held are discarded with the pointers.
      wr_row       <= 2'd0;
      old_row      <= 2'd0;
      wr_col       <= '0;
      rd_col       <= '0;
      rows_written <= '0;
      windows_done <= '0;
      filled       <= 2'd0;
    end else begin
      if (wr_accept) begin
        wr_col <= row_done ? '0 : wr_col + CW'(1);
        if (row_done) begin
          wr_row       <= row_inc(wr_row);
          rows_written <= rows_written + RW'(1);
        end
      end
      if (rd_accept) begin
        rd_col <= row_release ? '0 : rd_col + CW'(1);
        if (row_release) begin
          old_row      <= row_inc(old_row);
          windows_done <= windows_done + RW'(1);
        end
      end
      filled <= filled_next;
    end
  end

  // Column outputs, one cycle after the accepted shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1_out    <= '0;
      l2_out    <= '0;
      l3_out    <= '0;
      col_valid <= 1'b0;
    end else begin
      col_valid <= rd_accept;
      if (rd_accept) begin
        l1_out <= mem[old_row][rd_col];
        l2_out <= mem[mid_row][rd_col];
        l3_out <= mem[new_row][rd_col];
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_3row
//
// Bench for line_buffer_3row with a 4x4 image. The reference model holds the
// accepted frame as a flat pixel array and derives readiness and window
// contents from pixel/column counts: complete rows = accepted/W, released
// rows = columns read/W, window k column c = rows k, k+1, k+2 at column c.
// ---------------------------------------------------------------------------
module tb_line_buffer_3row;

  localparam int BD = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [BD-1:0] pix_in;
  logic          pix_valid, pix_ready, shift_buffer;
  logic [BD-1:0] l1_out, l2_out, l3_out;
  logic          col_valid, rows_ready, frame_done;
  logic [1:0]    fsm_state;

  line_buffer_3row #(.BIT_DEPTH(BD), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .shift_buffer(shift_buffer),
    .l1_out(l1_out), .l2_out(l2_out), .l3_out(l3_out),
    .col_valid(col_valid), .rows_ready(rows_ready),
    .frame_done(frame_done), .fsm_state(fsm_state)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [3*BD-1:0] exp_q[$];
  logic [3*BD-1:0] last_out;

  // reference model
  logic [BD-1:0] frame_pix [H*W];
  int acc_cnt;
  int rd_cnt;
  bit flushing;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_pix_ready();
    int held;
    held = acc_cnt / W - rd_cnt / W;
    return !flushing && (held < 3) && (acc_cnt / W < H);
  endfunction

  function automatic bit model_rows_ready();
    return !flushing && (acc_cnt / W - rd_cnt / W == 3);
  endfunction

  function automatic logic [3*BD-1:0] model_window();
    int k, c;
    k = rd_cnt / W;
    c = rd_cnt % W;
    return {frame_pix[k*W + c], frame_pix[(k+1)*W + c], frame_pix[(k+2)*W + c]};
  endfunction

  function automatic logic [BD-1:0] pv_of(input int row, input int col);
    return BD'(16*row + col);
  endfunction

  // Asynchronous reset pulse applied mid-cycle; outputs checked before any edge.
  task automatic do_reset();
    pix_valid = 1'b0; shift_buffer = 1'b0; pix_in = '0;
    rst = 1'b1;
    #1;
    check("rst_l123", {8'h0, l1_out, l2_out, l3_out}, 32'h0);
    check("rst_col_valid", col_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_ready", pix_ready, 1);
    check("rst_rows_ready", rows_ready, 0);
    check("rst_state", fsm_state, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    acc_cnt = 0; rd_cnt = 0; flushing = 0;
    exp_q.delete();
    last_out = '0;
  endtask

  // One clock cycle of stimulus, entered and left just after a falling edge.
  task automatic step(input logic pv, input logic [BD-1:0] px, input logic sb);
    bit acc, rd;
    pix_valid = pv; pix_in = px; shift_buffer = sb;
    #1;
    check("pix_ready", pix_ready, model_pix_ready());
    check("rows_ready", rows_ready, model_rows_ready());
    check("frame_done", frame_done, flushing);
    acc = pv && model_pix_ready();
    rd  = sb && model_rows_ready();
    if (rd) exp_q.push_back(model_window());
    @(posedge clk);
    #1;
    check("col_valid", col_valid, rd);
    if (rd) last_out = exp_q.pop_front();
    check("window", {8'h0, l1_out, l2_out, l3_out}, {8'h0, last_out});
    if (flushing) begin
      flushing = 0; acc_cnt = 0; rd_cnt = 0;
    end else begin
      if (acc) begin
        frame_pix[acc_cnt] = px;
        acc_cnt++;
      end
      if (rd) begin
        rd_cnt++;
        if (rd_cnt == (H-2)*W) flushing = 1;
      end
    end
    @(negedge clk);
    pix_valid = 1'b0; shift_buffer = 1'b0;
  endtask

  task automatic feed_rows(input int first_row, input int n_rows);
    for (int r = first_row; r < first_row + n_rows; r++)
      for (int c = 0; c < W; c++) step(1'b1, pv_of(r, c), 1'b0);
  endtask

  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    pix_valid = 1'b0; shift_buffer = 1'b0; pix_in = '0;
    @(negedge clk);
    do_reset();

    // Full frame with pix_valid held high, then two windows.
    feed_rows(0, 3);
    check("fill_ready_drop", pix_ready, 0);
    check("fill_rows_ready", rows_ready, 1);
    step(1'b0, '0, 1'b1);
    check("first_col", {8'h0, l1_out, l2_out, l3_out}, {8'h0, 8'd0, 8'd16, 8'd32});
    shifts(3);
    check("last_col_w0", {8'h0, l1_out, l2_out, l3_out}, {8'h0, 8'd3, 8'd19, 8'd35});
    feed_rows(3, 1);
    shifts(4);
    check("last_col_w1", {8'h0, l1_out, l2_out, l3_out}, {8'h0, 8'd19, 8'd35, 8'd51});
    check("frame_done_pulse", frame_done, 1);
    step(1'b0, '0, 1'b0);
    check("ready_after_flush", pix_ready, 1);
    check("frame_done_gone", frame_done, 0);

    // Shift ignored with two rows held; pixel refused with three rows held.
    feed_rows(0, 2);
    shifts(2);
    feed_rows(2, 1);
    step(1'b1, 8'hAA, 1'b0);
    // Row 3 offered while window 0 is still being consumed.
    for (int c = 0; c < W; c++) step(1'b1, pv_of(3, c), 1'b1);
    feed_rows(3, 1);
    shifts(4);
    step(1'b0, '0, 1'b0);

    // Reset mid-frame, then a fresh fill starts at row 0 column 0.
    feed_rows(0, 1);
    step(1'b1, pv_of(1, 0), 1'b0);
    step(1'b1, pv_of(1, 1), 1'b0);
    do_reset();
    feed_rows(0, 3);
    step(1'b0, '0, 1'b1);
    check("post_rst_first", {8'h0, l1_out, l2_out, l3_out}, {8'h0, 8'd0, 8'd16, 8'd32});
    shifts(3);
    feed_rows(3, 1);
    shifts(4);
    step(1'b0, '0, 1'b0);

    // Random traffic with bubbles on both sides across several frames.
    for (int i = 0; i < 3000; i++)
      step(1'b1 & ($urandom_range(0, 2) != 0), BD'($urandom), $urandom_range(0, 1) == 1);

    // Random reset in the middle of random traffic.
    for (int i = 0; i < 13; i++)
      step(1'b1, BD'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 1) == 1, BD'($urandom), $urandom_range(0, 3) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
